// File: rtl/if_redirect.sv
// Instruction-fetch stage with exception/branch redirect and one-word drop after redirect.
// Optional feature macro: FETCH_ALIGN_CHECK_EN -- flags misaligned fetch pcs and zeroes their instruction word.
module if_redirect #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [32:0] exc_bus,
  input  logic        cancel,
  input  logic [32:0] jbr_bus,
  input  logic        next_fetch,
  input  logic [31:0] inst_rdata,
  output logic [31:0] inst_addr,
  output logic        IF_valid,
  output logic        IF_over,
  output logic [64:0] IF_ID_bus,
  output logic [31:0] IF_pc
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned BUS_W  = 65;
  localparam int unsigned PC_INC = 4;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_DATA = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  typedef struct packed {
    logic            fetch_error;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } if_id_t;

  state_t          state_q;
  state_t          state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic            valid_q;
  logic            valid_d;
  logic            pend_q;
  logic            pend_d;
  logic [XLEN-1:0] tgt_q;
  logic [XLEN-1:0] tgt_d;
  logic            capture;
  if_id_t          bus_q;
  if_id_t          bundle;
  logic [XLEN-1:0] ifpc_q;

  logic            exc_valid;
  logic [XLEN-1:0] exc_pc;
  logic            jbr_taken;
  logic [XLEN-1:0] jbr_target;
  logic [XLEN-1:0] seq_pc;

  assign exc_valid  = exc_bus[32];
  assign exc_pc     = exc_bus[31:0];
  assign jbr_taken  = jbr_bus[32];
  assign jbr_target = jbr_bus[31:0];

  // Sequential successor: a pending branch target wins over pc+4 (wraps at 2^32).
  assign seq_pc = pend_q ? tgt_q : (pc_q + XLEN'(PC_INC));

  // Bundle formed from the current pc and the returning ROM word.
`ifdef FETCH_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned         = |pc_q[1:0];
  assign bundle.fetch_error = misaligned;
  assign bundle.pc          = pc_q;
  assign bundle.inst        = misaligned ? '0 : inst_rdata;
`else
  assign bundle.fetch_error = 1'b0;
  assign bundle.pc          = pc_q;
  assign bundle.inst        = inst_rdata;
`endif

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath control; an exception redirect overrides everything.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    pend_d  = pend_q;
    tgt_d   = tgt_q;
    capture = 1'b0;

    if (exc_valid) begin
      pc_d    = exc_pc;
      pend_d  = 1'b0;
      valid_d = 1'b0;
      // A fetch already in flight returns a stale word next cycle; skip it.
      state_d = (state_q == ST_REQ) ? ST_DROP : ST_REQ;
    end else begin
      if (cancel) begin
        // Flush without redirect: drop the bundle and refetch the same pc.
        valid_d = 1'b0;
        state_d = ST_REQ;
      end else begin
        unique case (state_q)
          ST_REQ: begin
            capture = 1'b1;
            valid_d = 1'b1;
            state_d = ST_DATA;
          end
          ST_DATA: begin
            if (next_fetch) begin
              pc_d    = seq_pc;
              pend_d  = 1'b0;
              valid_d = 1'b0;
              state_d = ST_REQ;
            end
          end
          ST_DROP: begin
            valid_d = 1'b0;
            state_d = ST_REQ;
          end
          default: begin
            valid_d = 1'b0;
            state_d = ST_REQ;
          end
        endcase
      end

      // Branch is remembered and applied at the following next_fetch (delay slot).
      if (jbr_taken && (state_q != ST_DROP)) begin
        pend_d = 1'b1;
        tgt_d  = jbr_target;
      end
    end
  end

  // Fetch pc, valid flag and pending-branch registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
      tgt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
      tgt_q   <= tgt_d;
    end
  end

  // Held bundle and its display pc; stable until the next capture.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus_q  <= '0;
      ifpc_q <= '0;
    end else if (capture) begin
      bus_q  <= bundle;
      ifpc_q <= pc_q;
    end
  end

  assign inst_addr = pc_q;
  assign IF_valid  = valid_q;
  assign IF_over   = valid_q;
  assign IF_ID_bus = BUS_W'(bus_q);
  assign IF_pc     = ifpc_q;

endmodule

// File: tb/tb_if_redirect.sv
// Self-checking bench for if_redirect: directed scenarios plus randomized traffic against a behavioural model.
module tb_if_redirect;

  localparam logic [31:0] RST_PC = 32'hBFC00000;
  localparam int PH_FETCH  = 0;
  localparam int PH_HOLD   = 1;
  localparam int PH_SQUASH = 2;

  logic        clk;
  logic        resetn;
  logic [32:0] exc_bus;
  logic        cancel;
  logic [32:0] jbr_bus;
  logic        next_fetch;
  logic [31:0] inst_rdata;
  logic [31:0] inst_addr;
  logic        IF_valid;
  logic        IF_over;
  logic [64:0] IF_ID_bus;
  logic [31:0] IF_pc;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  logic [31:0] m_tgt;
  logic [31:0] m_ifpc;
  logic [64:0] m_bus;
  logic        m_valid;
  logic        m_pend;
  int          m_ph;

  if_redirect dut (
    .clk        (clk),
    .resetn     (resetn),
    .exc_bus    (exc_bus),
    .cancel     (cancel),
    .jbr_bus    (jbr_bus),
    .next_fetch (next_fetch),
    .inst_rdata (inst_rdata),
    .inst_addr  (inst_addr),
    .IF_valid   (IF_valid),
    .IF_over    (IF_over),
    .IF_ID_bus  (IF_ID_bus),
    .IF_pc      (IF_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0F1E2D3C;
  endfunction

  // ROM presents the word for the address held during the request cycle.
  assign inst_rdata = rom_word(inst_addr);

  function automatic logic [64:0] make_bundle(input logic [31:0] pc, input logic [31:0] w);
`ifdef FETCH_ALIGN_CHECK_EN
    if (pc[1:0] != 2'b00) return {1'b1, pc, 32'd0};
`endif
    return {1'b0, pc, w};
  endfunction

  task automatic model_reset();
    m_pc    = RST_PC;
    m_tgt   = '0;
    m_ifpc  = '0;
    m_bus   = '0;
    m_valid = 1'b0;
    m_pend  = 1'b0;
    m_ph    = PH_FETCH;
  endtask

  // Advance the model across one rising edge using the inputs currently applied.
  task automatic model_edge();
    logic jseen;
    if (!resetn) begin
      model_reset();
      return;
    end
    if (exc_bus[32]) begin
      m_ph    = (m_ph == PH_FETCH) ? PH_SQUASH : PH_FETCH;
      m_pc    = exc_bus[31:0];
      m_pend  = 1'b0;
      m_valid = 1'b0;
      return;
    end
    jseen = jbr_bus[32] && (m_ph != PH_SQUASH);
    if (cancel) begin
      m_valid = 1'b0;
      m_ph    = PH_FETCH;
    end else if (m_ph == PH_FETCH) begin
      m_bus   = make_bundle(m_pc, rom_word(m_pc));
      m_ifpc  = m_pc;
      m_valid = 1'b1;
      m_ph    = PH_HOLD;
    end else if (m_ph == PH_HOLD) begin
      if (next_fetch) begin
        m_pc    = m_pend ? m_tgt : m_pc + 32'd4;
        m_pend  = 1'b0;
        m_valid = 1'b0;
        m_ph    = PH_FETCH;
      end
    end else begin
      m_ph = PH_FETCH;
    end
    if (jseen) begin
      m_pend = 1'b1;
      m_tgt  = jbr_bus[31:0];
    end
  endtask

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("inst_addr", 65'(inst_addr), 65'(m_pc));
    chk("IF_valid",  65'(IF_valid),  65'(m_valid));
    chk("IF_over",   65'(IF_over),   65'(m_valid));
    chk("IF_ID_bus", IF_ID_bus,      m_bus);
    chk("IF_pc",     65'(IF_pc),     65'(m_ifpc));
  endtask

  // One clock: model advances, DUT outputs sampled on the falling edge.
  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    #1;
    resetn = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    step();
    resetn = 1'b1;
  endtask

  logic [64:0] held;
  logic [64:0] exp_err;
  logic [64:0] exp_inst;
  logic [31:0] r;

  initial begin
    resetn     = 1'b1;
    exc_bus    = '0;
    jbr_bus    = '0;
    cancel     = 1'b0;
    next_fetch = 1'b1;
    model_reset();
    #2 resetn = 1'b0;
    #1;
    check_all();
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // Sequential fetch from reset
    chk("rst_addr", 65'(inst_addr), 65'(32'hBFC00000));
    chk("rst_bus", IF_ID_bus, 65'd0);
    step();
    chk("first_over", 65'(IF_over), 65'd1);
    chk("first_pc", 65'(IF_pc), 65'(32'hBFC00000));
    step();
    chk("addr_04", 65'(inst_addr), 65'(32'hBFC00004));
    chk("req_over", 65'(IF_over), 65'd0);
    step();

    // Branch with delay slot
    jbr_bus = {1'b1, 32'hBFC00100};
    step();
    jbr_bus = '0;
    chk("delay_slot", 65'(inst_addr), 65'(32'hBFC00008));
    step();
    step();
    chk("br_target", 65'(inst_addr), 65'(32'hBFC00100));
    step();
    step();
    chk("addr_104", 65'(inst_addr), 65'(32'hBFC00104));

    // Exception in request state, coinciding with a branch
    exc_bus = {1'b1, 32'hBFC00380};
    jbr_bus = {1'b1, 32'h00004000};
    step();
    exc_bus = '0;
    jbr_bus = '0;
    chk("drop_over", 65'(IF_over), 65'd0);
    chk("drop_addr", 65'(inst_addr), 65'(32'hBFC00380));
    step();
    chk("drop_over2", 65'(IF_over), 65'd0);
    step();
    chk("exc_ifpc", 65'(IF_pc), 65'(32'hBFC00380));
    chk("exc_over", 65'(IF_over), 65'd1);
    step();
    chk("no_branch", 65'(inst_addr), 65'(32'hBFC00384));
    step();

    // Stall five cycles with a cancel in the third
    next_fetch = 1'b0;
    held = IF_ID_bus;
    for (int i = 1; i <= 5; i++) begin
      cancel = (i == 3);
      step();
      cancel = 1'b0;
      chk("hold_bus", IF_ID_bus, held);
      chk("hold_addr", 65'(inst_addr), 65'(32'hBFC00384));
      if (i == 3) chk("cancel_valid", 65'(IF_valid), 65'd0);
    end

    // Misaligned redirect
    next_fetch = 1'b1;
    exc_bus = {1'b1, 32'hBFC00002};
    step();
    exc_bus = '0;
    step();
`ifdef FETCH_ALIGN_CHECK_EN
    exp_err  = 65'd1;
    exp_inst = 65'd0;
`else
    exp_err  = 65'd0;
    exp_inst = 65'(rom_word(32'hBFC00002));
`endif
    chk("align_err", 65'(IF_ID_bus[64]), exp_err);
    chk("align_inst", 65'(IF_ID_bus[31:0]), exp_inst);

    // pc+4 wrap at the top of the address space
    exc_bus = {1'b1, 32'hFFFFFFFC};
    step();
    exc_bus = '0;
    step();
    step();
    chk("wrap", 65'(inst_addr), 65'd0);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      r = $urandom;
      if ($urandom_range(0, 7) != 0) r[1:0] = 2'b00;
      exc_bus = {($urandom_range(0, 29) == 0), r};
      r = $urandom;
      if ($urandom_range(0, 7) != 0) r[1:0] = 2'b00;
      jbr_bus    = {($urandom_range(0, 9) == 0), r};
      cancel     = ($urandom_range(0, 29) == 0);
      next_fetch = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_redirect.md
IF_REDIRECT -- requirements
Module: if_redirect

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'hBFC00000, the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port exc_bus  input  33  {exc_valid, exc_pc[31:0]}: exception, interrupt or eret redirect from the write-back stage.
REQ-005 SHALL have port cancel  input  1  flush of in-flight younger instructions, asserted by write-back on exception or eret.
REQ-006 SHALL have port jbr_bus  input  33  {jbr_taken, jbr_target[31:0]}: taken jump or branch from decode.
REQ-007 SHALL have port next_fetch  input  1  decode accepts the current fetched bundle this cycle.
REQ-008 SHALL have port inst_rdata  input  32  instruction word from synchronous ROM, valid one cycle after inst_addr.
REQ-009 SHALL have port inst_addr  output  32  ROM address; equals the current pc.
REQ-010 SHALL have port IF_valid  output  1  the fetch stage holds a live instruction.
REQ-011 SHALL have port IF_over  output  1  fetched bundle ready for decode.
REQ-012 SHALL have port IF_ID_bus  output  65  {fetch_error, pc[31:0], inst[31:0]}.
REQ-013 SHALL have port IF_pc  output  32  pc of the bundle currently held, for display.

Function
REQ-014 SHALL implement a three-state FSM: REQ (address issued), DATA (word latched, waiting on decode), DROP (discard one returning word after a redirect).
REQ-015 In REQ, the SHALL capture inst_rdata with its pc on the next edge and move to DATA; fetch latency SHALL be exactly 1 cycle from inst_addr to IF_over.
REQ-016 In DATA, IF_over SHALL be 1; the bundle SHALL be held stable until next_fetch=1.
REQ-017 When next_fetch=1 in DATA, pc SHALL load next_pc, and the FSM SHALL return to REQ.
REQ-018 next_pc priority SHALL be: exc_pc if exc_valid; else the pending branch target if jbr_pend; else pc+4, with 32-bit wrap (32'hFFFFFFFC+4 = 0).
REQ-019 A jbr_taken seen while in REQ or DATA SHALL set jbr_pend and store jbr_target; the target SHALL be applied only at the next next_fetch, so the delay slot is still fetched.
REQ-020 jbr_pend SHALL clear when its target is loaded into pc, or on exc_valid.
REQ-021 exc_valid=1 in any state SHALL load pc with exc_pc on the same edge, clear jbr_pend and clear IF_valid.
REQ-022 exc_valid=1 in REQ SHALL move the FSM to DROP, not DATA, because the stale word returns next cycle.
REQ-023 DROP SHALL ignore inst_rdata for one cycle, then go to REQ with inst_addr=exc_pc.
REQ-024 cancel=1 without exc_valid SHALL clear IF_valid and discard the held bundle; pc SHALL be unchanged.
REQ-025 When exc_valid and cancel are both 1, the exc_valid behaviour SHALL apply.
REQ-026 When exc_valid and jbr_taken coincide, jbr_taken SHALL be ignored.
REQ-027 IF_valid SHALL be 1 only in DATA with a non-flushed bundle; IF_over SHALL equal IF_valid in DATA.

Reset
REQ-028 On resetn=0, asynchronously: pc=RESET_PC, FSM=REQ, IF_valid=0, IF_over=0, jbr_pend=0, IF_ID_bus=0, IF_pc=0.
REQ-029 After resetn deasserts, inst_addr SHALL be RESET_PC on the first clock, and the first IF_over SHALL follow one cycle later.
REQ-030 A reset mid-fetch or in DROP SHALL abandon the outstanding word without any IF_over.

Configuration
REQ-031 With FETCH_ALIGN_CHECK_EN defined, fetch_error SHALL be 1 when pc[1:0]!=0, and inst in that bundle SHALL be forced to 32'd0.
REQ-032 Without FETCH_ALIGN_CHECK_EN, fetch_error SHALL be tied to 0 and inst SHALL pass unchanged.

Verification
REQ-033 Reset release with next_fetch=1 held high -> inst_addr sequence BFC00000, BFC00004, BFC00008; one IF_over per 2 cycles.
REQ-034 jbr_taken with target 0xBFC00100 while fetching 0xBFC00004 -> next fetches are 0xBFC00008 (delay slot), then 0xBFC00100.
REQ-035 exc_bus={1,0xBFC00380} in REQ -> state DROP with no IF_over; next inst_addr is 0xBFC00380; jbr_pend cleared.
REQ-036 next_fetch=0 for 5 cycles in DATA -> IF_ID_bus stable for all 5 cycles; a cancel in cycle 3 drops IF_valid, and pc is unchanged.
REQ-037 Redirect to 0xBFC00002 with FETCH_ALIGN_CHECK_EN defined -> fetch_error=1, inst=0; without the macro -> fetch_error=0.
REQ-038 exc_valid and jbr_taken in the same cycle -> pc=exc_pc, and the branch target is never fetched.
